// File: rtl/key_pio_debounce_if.sv
// ---------------------------------------------------------------------------
// key_pio_debounce_if
//
// Avalon-MM bus bundle for the debounced key/switch PIO. The Nios data bus
// master drives the address/strobe/data group and gets registered read
// data back one clock later.
//
// Signals:
//   address    [2:0]   word address of the register being accessed
//   chipselect         slave select
//   write_n            active-low write strobe
//   writedata  [31:0]  write data
//   readdata   [31:0]  registered read data (one clock of read latency)
// ---------------------------------------------------------------------------
interface key_pio_debounce_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  // The bus master (Nios data master or a bench) drives the request side
  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  // The PIO answers with registered read data
  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/key_pio_debounce.sv
// ---------------------------------------------------------------------------
// key_pio_debounce
//
// WIDTH-channel input PIO for board pushbuttons and switches. Every channel
// is passed through a 2-flop synchroniser and a debounce filter. A debounced
// level change produces a one-cycle edge pulse (qualified by EDGE_TYPE). That
// pulse sets a sticky edge-capture bit, which software clears by writing 1.
// The interrupt is taken either from the debounced levels or from the
// captured edges, gated by a per-bit mask.
//
// Ports:
//   clk      system clock
//   reset    asynchronous reset, active-high
//   bus      Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   in_port  raw asynchronous pin inputs, WIDTH bits
//   irq      interrupt request, combinational from registers
//
// Register map (word addresses, bits above WIDTH read as 0):
//   0  data          debounced pin levels, read-only
//   1  reserved      reads 0
//   2  irq_mask      read/write
//   3  edge_capture  read; writing 1 clears a bit, writing 0 has no effect
//   4  event_cnt     16-bit edge-event counter (optional, see below)
//   5-7              read 0, writes ignored
//
// Optional feature: define KEY_PIO_EVENT_CNT_EN to build a saturating 16-bit
// counter at address 4. It counts cycles on which any channel produced an
// edge, and any write to address 4 clears it. Without the macro, address 4
// reads 0 and no counter logic exists.
// ---------------------------------------------------------------------------
module key_pio_debounce #(
  parameter int               WIDTH           = 4,
  parameter int               EDGE_TYPE       = 1,
  parameter int               IRQ_TYPE        = 1,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] IDLE_VALUE      = {WIDTH{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  key_pio_debounce_if.slave bus,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  localparam bit BYPASS = (DEBOUNCE_CYCLES <= 1);
  localparam int CNT_W  = BYPASS ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = BYPASS ? '0 : CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_EVENT   = 3'd4;

  logic [WIDTH-1:0] sync1Q;
  logic [WIDTH-1:0] sync2Q;
  logic [WIDTH-1:0] stableQ;
  logic [WIDTH-1:0] stableD;
  logic [WIDTH-1:0] prevQ;
  logic [CNT_W-1:0] cntQ [WIDTH];
  logic [CNT_W-1:0] cntD [WIDTH];

  logic [WIDTH-1:0] riseBits;
  logic [WIDTH-1:0] fallBits;
  logic [WIDTH-1:0] edgeBits;
  logic             anyEdge;

  logic             wrEn;
  logic [WIDTH-1:0] wrBits;
  logic [WIDTH-1:0] clearBits;
  logic [WIDTH-1:0] irqMaskQ;
  logic [WIDTH-1:0] irqMaskD;
  logic [WIDTH-1:0] edgeCaptureQ;
  logic [WIDTH-1:0] edgeCaptureD;

  logic [31:0]      eventCntRd;
  logic [31:0]      readdataQ;
  logic [31:0]      readdataD;

  // Only the low WIDTH write-data bits have any meaning. The rest are folded
  // here so the unused upper bits are visibly intentional.
  logic             unusedWriteBits;
  assign unusedWriteBits = ^bus.writedata;

  // Two-flop synchroniser. The pins are fully asynchronous, so nothing
  // downstream may look at in_port directly. The flops reset to the idle
  // level so a reset does not look like a key press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1Q <= IDLE_VALUE;
      sync2Q <= IDLE_VALUE;
    end else begin
      sync1Q <= in_port;
      sync2Q <= sync1Q;
    end
  end

  // Debounce filter, one counter per channel. The counter only runs while
  // the synchronised pin disagrees with the accepted level. Any agreement
  // restarts it, so only an unbroken run of DEBOUNCE_CYCLES disagreeing
  // samples moves the accepted level. With 0 or 1 cycles requested the
  // filter degenerates into a plain register after the synchroniser.
  always_comb begin
    stableD = stableQ;
    for (int i = 0; i < WIDTH; i++) begin
      cntD[i] = '0;
      if (BYPASS) begin
        stableD[i] = sync2Q[i];
      end else if (sync2Q[i] != stableQ[i]) begin
        if (cntQ[i] == CNT_LAST) begin
          stableD[i] = sync2Q[i];
        end else begin
          cntD[i] = cntQ[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced level, its one-cycle-delayed copy for edge detection, and the
  // per-channel counters. After reset every channel starts again from the
  // idle level with an empty counter. Because prev also resets to idle, a
  // reset never manufactures an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stableQ <= IDLE_VALUE;
      prevQ   <= IDLE_VALUE;
      for (int i = 0; i < WIDTH; i++) begin
        cntQ[i] <= '0;
      end
    end else begin
      stableQ <= stableD;
      prevQ   <= stableQ;
      for (int i = 0; i < WIDTH; i++) begin
        cntQ[i] <= cntD[i];
      end
    end
  end

  // Edge qualification. Rising, falling or either direction, chosen at
  // elaboration time. Keys idle high, so a press is a falling edge.
  always_comb begin
    riseBits = stableQ & ~prevQ;
    fallBits = ~stableQ & prevQ;
    case (EDGE_TYPE)
      0:       edgeBits = riseBits;
      1:       edgeBits = fallBits;
      default: edgeBits = riseBits | fallBits;
    endcase
    anyEdge = |edgeBits;
  end

  // Bus write decode. A write happens on any clock where the slave is
  // selected with write_n low. The capture clear is a pure bit mask, so
  // writing 0 to a bit leaves that bit alone.
  always_comb begin
    wrEn      = bus.chipselect && !bus.write_n;
    wrBits    = bus.writedata[WIDTH-1:0];
    irqMaskD  = irqMaskQ;
    clearBits = '0;
    if (wrEn && (bus.address == ADDR_MASK)) begin
      irqMaskD = wrBits;
    end
    if (wrEn && (bus.address == ADDR_CAPTURE)) begin
      clearBits = wrBits;
    end
    // The set term is applied after the clear so an edge arriving in the
    // same cycle as its own clear is kept rather than silently dropped.
    edgeCaptureD = (edgeCaptureQ & ~clearBits) | edgeBits;
  end

  // Mask and capture registers. Both start empty so no interrupt can fire
  // before software has configured the PIO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqMaskQ     <= '0;
      edgeCaptureQ <= '0;
    end else begin
      irqMaskQ     <= irqMaskD;
      edgeCaptureQ <= edgeCaptureD;
    end
  end

`ifdef KEY_PIO_EVENT_CNT_EN
  logic [15:0] eventCntQ;
  logic [15:0] eventCntD;

  // Event counter. It counts cycles with at least one qualified edge, not
  // individual bits, and sticks at all-ones instead of wrapping. A clear
  // that lands on an edge cycle leaves 1 so that event is still counted.
  always_comb begin
    eventCntD = eventCntQ;
    if (wrEn && (bus.address == ADDR_EVENT)) begin
      eventCntD = anyEdge ? 16'd1 : 16'd0;
    end else if (anyEdge && (eventCntQ != 16'hFFFF)) begin
      eventCntD = eventCntQ + 16'd1;
    end
  end

  // Event counter state, cleared by reset like everything else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eventCntQ <= '0;
    end else begin
      eventCntQ <= eventCntD;
    end
  end

  assign eventCntRd = 32'(eventCntQ);
`else
  assign eventCntRd = 32'd0;
`endif

  // Read multiplexer. It is evaluated every cycle whatever chipselect is
  // doing. The master allows one read wait state, so registering the result
  // costs nothing and keeps the bus path short.
  always_comb begin
    readdataD = 32'd0;
    case (bus.address)
      ADDR_DATA:    readdataD = 32'(stableQ);
      ADDR_MASK:    readdataD = 32'(irqMaskQ);
      ADDR_CAPTURE: readdataD = 32'(edgeCaptureQ);
      ADDR_EVENT:   readdataD = eventCntRd;
      default:      readdataD = 32'd0;
    endcase
  end

  // Registered read data, zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdataQ <= '0;
    end else begin
      readdataQ <= readdataD;
    end
  end

  assign bus.readdata = readdataQ;

  // Interrupt. Edge mode follows the sticky capture bits, so it stays high
  // until software acknowledges. Level mode follows the debounced pins.
  generate
    if (IRQ_TYPE == 1) begin : gIrqEdge
      assign irq = |(edgeCaptureQ & irqMaskQ);
    end else begin : gIrqLevel
      assign irq = |(stableQ & irqMaskQ);
    end
  endgenerate

endmodule
